// File: rtl/teclado_pkg.sv
// teclado_pkg
// Shared definitions for the keyboard sequencing controller:
//   - frame_state_e : PS/2 frame receiver states
//   - EV_BRK/EV_EXT/EV_VALID : bit positions inside a key event word
//   - PFX_EXT/PFX_BRK : scan-code prefixes (E0 extended, F0 break)
//   - make_event() : builds a 32-bit event word from code and flags
package teclado_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam int EV_BRK   = 8;
  localparam int EV_EXT   = 9;
  localparam int EV_VALID = 10;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Event word: [7:0] code, [8] break, [9] extended, [10] valid, rest zero.
  function automatic logic [31:0] make_event(input logic [7:0] code,
                                             input logic       brk,
                                             input logic       ext);
    logic [31:0] ev;
    ev           = '0;
    ev[7:0]      = code;
    ev[EV_BRK]   = brk;
    ev[EV_EXT]   = ext;
    ev[EV_VALID] = 1'b1;
    return ev;
  endfunction

endpackage

// File: rtl/teclado_ctrl_if.sv
// teclado_ctrl_if
// Keyboard-register port bundle.
//   bus_we : bus-side write enable to the keyboard register (we_1) this cycle
//   reg_q  : current keyboard register contents
//   we_2   : keyboard-side write strobe
//   data_2 : keyboard-side write data
// master = the controller, slave = the register / bus side.
interface teclado_ctrl_if;
  logic        bus_we;
  logic [31:0] reg_q;
  logic        we_2;
  logic [31:0] data_2;

  modport master (
    input  bus_we,
    input  reg_q,
    output we_2,
    output data_2
  );

  modport slave (
    output bus_we,
    output reg_q,
    input  we_2,
    input  data_2
  );
endinterface

// File: rtl/teclado_ctrl_ps2_rx_frame.sv
// ps2_rx_frame
// PS/2 receiver front end: 2-flop synchronizers on both pins, a level filter
// on ps2_clk, the 11-bit frame FSM (start, 8 data LSB first, odd parity,
// stop) and an inactivity timeout.
// Ports:
//   clk_i, reset_i        : system clock, synchronous active-high reset
//   ps2_clk_i, ps2_data_i : asynchronous PS/2 pins
//   byte_stb_o            : one-cycle strobe, byte_o holds a good byte
//   byte_o                : received byte
//   err_stb_o             : one-cycle strobe, frame discarded (parity/stop/timeout)
module ps2_rx_frame
  import teclado_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_stb_o,
  output logic [7:0] byte_o,
  output logic       err_stb_o
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]     r_clk_sync;
  logic [1:0]     r_dat_sync;
  logic           r_clk_filt;
  logic [FCW-1:0] r_filt_cnt;
  frame_state_e   r_state;
  frame_state_e   w_state_next;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_par;
  logic           r_par_ok;
  logic [TCW-1:0] r_to_cnt;
  logic           r_byte_stb;
  logic [7:0]     r_byte;
  logic           r_err_stb;

  logic w_clk_s;
  logic w_dat_s;
  logic w_filt_flip;
  logic w_fall;
  logic w_timeout;
  logic w_stop_fall;
  logic w_byte_stb;
  logic w_err_stb;

  // Pins idle high, so the synchronizers reset to 1 to avoid a fake edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_i};
      r_dat_sync <= {r_dat_sync[0], ps2_data_i};
    end
  end

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];

  // The counter tracks how many consecutive samples differ from the filtered
  // level; the level flips on the FILTER_LEN-th one.
  assign w_filt_flip = (w_clk_s != r_clk_filt) && (r_filt_cnt == FCW'(FILTER_LEN - 1));
  assign w_fall      = w_filt_flip && r_clk_filt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (w_filt_flip) begin
      r_clk_filt <= w_clk_s;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FCW'(1);
    end
  end

  // A falling edge in the expiry cycle still counts as activity.
  assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                     (r_to_cnt == TCW'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = ST_IDLE;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE:   if (!w_dat_s) w_state_next = ST_DATA;
        ST_DATA:   if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
        ST_PARITY: w_state_next = ST_STOP;
        ST_STOP:   w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_stop_fall = w_fall && (r_state == ST_STOP);
    w_byte_stb  = w_stop_fall && w_dat_s && r_par_ok;
    w_err_stb   = w_timeout || (w_stop_fall && !(w_dat_s && r_par_ok));
  end

  // Datapath: shift register, running parity, timeout counter, strobes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_par_ok   <= 1'b0;
      r_to_cnt   <= '0;
      r_byte_stb <= 1'b0;
      r_byte     <= '0;
      r_err_stb  <= 1'b0;
    end else begin
      r_byte_stb <= w_byte_stb;
      r_err_stb  <= w_err_stb;
      if (w_byte_stb) r_byte <= r_shift;

      if (r_state == ST_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
      else                                           r_to_cnt <= r_to_cnt + TCW'(1);

      if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
          end
          ST_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_par     <= r_par ^ w_dat_s;
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          // Odd parity: data bits XOR parity bit must be 1.
          ST_PARITY: r_par_ok <= r_par ^ w_dat_s;
          default: ;
        endcase
      end
    end
  end

  assign byte_stb_o = r_byte_stb;
  assign byte_o     = r_byte;
  assign err_stb_o  = r_err_stb;

endmodule

// File: rtl/teclado_ctrl.sv
// teclado_ctrl
// Sequencing controller for the memory-mapped keyboard register. Receives
// PS/2 frames, decodes E0/F0 prefixes, queues key events in a small FIFO and
// writes them into the register through its keyboard-side port only after
// the CPU has cleared the valid bit, never alongside a bus-side write.
// Optional feature macro: TECLADO_BREAK_FILTER_EN -- when defined, key
// release (F0) events are dropped before the FIFO.
// Ports:
//   clk_i, reset_i        : 10 MHz system clock, synchronous active-high reset
//   ps2_clk_i, ps2_data_i : asynchronous PS/2 pins
//   reg_if (master)       : bus_we/reg_q in, we_2/data_2 out
//   frame_err_o           : one-cycle pulse per discarded frame
//   overflow_o            : sticky, an event was dropped on a full FIFO
module teclado_ctrl
  import teclado_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ps2_clk_i,
  input  logic                  ps2_data_i,
  teclado_ctrl_if.master        reg_if,
  output logic                  frame_err_o,
  output logic                  overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        w_byte_stb;
  logic [7:0]  w_byte;
  logic        w_err_stb;

  logic        r_ext;
  logic        r_brk;
  logic        r_overflow;
  logic        r_we_2_d;
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic        w_is_code;
  logic        w_push;
  logic        w_push_ok;
  logic        w_empty;
  logic        w_full;
  logic        w_issue;
  logic [31:0] w_event;
  logic        w_unused_q;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .byte_stb_o (w_byte_stb),
    .byte_o     (w_byte),
    .err_stb_o  (w_err_stb)
  );

  assign w_is_code = w_byte_stb && (w_byte != PFX_EXT) && (w_byte != PFX_BRK);
  assign w_event   = make_event(w_byte, r_brk, r_ext);

`ifdef TECLADO_BREAK_FILTER_EN
  assign w_push = w_is_code && !r_brk;
`else
  assign w_push = w_is_code;
`endif

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Issue is combinational on bus_we so the two strobes can never overlap.
  // r_we_2_d enforces the hold-off cycle while reg_q catches up.
  assign w_issue = !reset_i && !w_empty && !reg_if.reg_q[EV_VALID] &&
                   !reg_if.bus_we && !r_we_2_d;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push_ok = w_push && (!w_full || w_issue);

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= w_event;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_we_2_d   <= 1'b0;
    end else begin
      r_we_2_d <= w_issue;
      if (w_push_ok)             r_wr_ptr   <= r_wr_ptr + (AW+1)'(1);
      if (w_issue)               r_rd_ptr   <= r_rd_ptr + (AW+1)'(1);
      if (w_push && !w_push_ok)  r_overflow <= 1'b1;
    end
  end

  // Prefix flags: set by E0/F0, cleared by any other byte (pushed or not)
  // and by a discarded frame.
  always_ff @(posedge clk_i) begin
    if (reset_i || w_err_stb) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_byte_stb) begin
      if (w_byte == PFX_EXT) begin
        r_ext <= 1'b1;
      end else if (w_byte == PFX_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign reg_if.we_2   = w_issue;
  assign reg_if.data_2 = w_issue ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign frame_err_o   = w_err_stb;
  assign overflow_o    = r_overflow;

  // Only the valid bit of the register matters here.
  assign w_unused_q = ^{reg_if.reg_q[31:EV_VALID+1], reg_if.reg_q[EV_VALID-1:0]};

endmodule

// File: tb/tb_teclado_ctrl.sv
module tb_teclado_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [31:0] bus_wdata;
  logic [31:0] reg_model;
  logic        frame_err;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int exp_wr = 0;
  logic prev_we = 1'b0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  teclado_ctrl_if u_if ();

  teclado_ctrl #(
    .FIFO_DEPTH  (4),
    .FILTER_LEN  (4),
    .TIMEOUT_CYC (2000)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_dat),
    .reg_if      (u_if),
    .frame_err_o (frame_err),
    .overflow_o  (overflow)
  );

  assign u_if.reg_q = reg_model;

  // Keyboard register model: bus write has priority.
  always @(posedge clk) begin
    if (reset)            reg_model <= '0;
    else if (u_if.bus_we) reg_model <= bus_wdata;
    else if (u_if.we_2)   reg_model <= u_if.data_2;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ev(input logic [7:0] code, input logic brk, input logic ext);
    return {21'd0, 1'b1, ext, brk, code};
  endfunction

  // Monitor: every keyboard-side write is a transaction checked against the queue.
  always @(negedge clk) begin
    if (!reset && u_if.we_2) begin
      $display("write data_2=0x%08h bus_we=%0b", u_if.data_2, u_if.bus_we);
      check_val("we2_with_buswe", {31'd0, u_if.bus_we}, 32'd0);
      check_val("we2_width", {31'd0, prev_we}, 32'd0);
      check_val("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check_val("data_2", u_if.data_2, exp_q.pop_front());
      wr_cnt <= wr_cnt + 1;
    end
    if (!reset && frame_err) begin
      $display("frame_err pulse");
      err_cnt <= err_cnt + 1;
    end
    prev_we <= u_if.we_2;
  end

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [7:0] v;
    v = b;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(v[i]);
    ps2_bit((~^v) ^ bad_par);
    ps2_bit(1'b1);
    repeat (20) @(posedge clk);
  endtask

  task automatic cpu_write(input logic [31:0] d);
    @(posedge clk);
    #1 u_if.bus_we = 1'b1;
    bus_wdata = d;
    @(posedge clk);
    #1 u_if.bus_we = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int target);
    for (int i = 0; i < 600 && wr_cnt < target; i++) @(negedge clk);
    @(negedge clk);
    check_val(tag, wr_cnt, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0;
    reset       = 1'b1;
    ps2_clk     = 1'b1;
    ps2_dat     = 1'b1;
    u_if.bus_we = 1'b0;
    bus_wdata   = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("rst_we_2", {31'd0, u_if.we_2}, 32'd0);
    check_val("rst_data_2", u_if.data_2, 32'd0);
    check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Plain make code
    exp_q.push_back(32'h41C);
    send_frame(8'h1C, 1'b0);
    exp_wr++;
    wait_writes("t1_write", exp_wr);
    check_val("t1_reg", reg_model, 32'h41C);
    cpu_write(32'd0);

    // Extended release E0 F0 75
`ifndef TECLADO_BREAK_FILTER_EN
    exp_q.push_back(ev(8'h75, 1'b1, 1'b1));
`endif
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
`ifdef TECLADO_BREAK_FILTER_EN
    repeat (300) @(negedge clk);
    check_val("t2_no_write", wr_cnt, exp_wr);
`else
    exp_wr++;
    wait_writes("t2_write", exp_wr);
    cpu_write(32'd0);
`endif

    // E0 prefix, bad parity frame, then 1C: flags must be clear
    e0 = err_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h33, 1'b1);
    check_val("t3_err_pulse", err_cnt, e0 + 1);
    exp_q.push_back(32'h41C);
    send_frame(8'h1C, 1'b0);
    exp_wr++;
    wait_writes("t3_write", exp_wr);
    check_val("t3_err_once", err_cnt, e0 + 1);
    cpu_write(32'd0);

    // Overflow: five events while the register holds a valid event
    cpu_write(32'h400);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) check_val("t4_ovf_before", {31'd0, overflow}, 32'd0);
      if (k < 4) exp_q.push_back(ev(8'h10 + 8'(k), 1'b0, 1'b0));
      send_frame(8'h10 + 8'(k), 1'b0);
    end
    check_val("t4_overflow", {31'd0, overflow}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      repeat (50) @(negedge clk);
      check_val("t4_held", wr_cnt, exp_wr);
      cpu_write(32'd0);
      exp_wr++;
      wait_writes("t4_write", exp_wr);
    end
    cpu_write(32'd0);
    repeat (100) @(negedge clk);
    check_val("t4_fifth_dropped", wr_cnt, exp_wr);

    // Bus write coinciding with a due issue
    cpu_write(32'h400);
    exp_q.push_back(32'h42A);
    send_frame(8'h2A, 1'b0);
    repeat (50) @(negedge clk);
    check_val("t5_pending", wr_cnt, exp_wr);
    @(posedge clk);
    #1 u_if.bus_we = 1'b1;
    bus_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("t5_deferred", wr_cnt, exp_wr);
    @(posedge clk);
    #1 u_if.bus_we = 1'b0;
    exp_wr++;
    wait_writes("t5_write", exp_wr);
    cpu_write(32'd0);

    // Timeout: abandon a frame after 4 data bits
    e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (1900) @(negedge clk);
    check_val("t6_no_early_err", err_cnt, e0);
    repeat (200) @(negedge clk);
    check_val("t6_timeout_err", err_cnt, e0 + 1);
    exp_q.push_back(32'h41C);
    send_frame(8'h1C, 1'b0);
    exp_wr++;
    wait_writes("t6_write", exp_wr);
    check_val("t6_sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
